// File: rtl/regfile_pkg.sv
// Shared defaults and the scoreboard entry type for the regfile_sb_s register file.
// Optional build macro for the top: REGFILE_BYPASS_EN (same-cycle writeback forwarding).
package regfile_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int TAG_W_DEF    = 4;

    typedef struct packed {
        logic                 busy;
        logic [TAG_W_DEF-1:0] tag;
    } sb_entry_t;

endpackage

// File: rtl/regfile_scoreboard_s.sv
// Busy/tag scoreboard: tracks in-flight producers per register and keeps a running busy count.
// With REGFILE_BYPASS_EN it also exposes the post-edge busy vector for forwarding reads.
module regfile_scoreboard_s
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int TAG_W    = TAG_W_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic [TAG_W-1:0]    issue_tag,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy,
`ifdef REGFILE_BYPASS_EN
    output logic [NUM_REGS-1:0] busy_next,
`endif
    output logic [AW:0]         busy_count
);

    logic [NUM_REGS-1:0] busy_d;
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_d [NUM_REGS];
    logic [AW:0]         inc;
    logic [AW:0]         dec;
    logic [AW:0]         count_d;

    always_comb begin
        busy_d  = busy;
        tag_d   = tag_q;
        inc     = '0;
        dec     = '0;
        count_d = busy_count;
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            // Only the producer whose tag is recorded may release the register.
            if (wb_valid && (wb_rd != '0) && busy[wb_rd] && (tag_q[wb_rd] == wb_tag)) begin
                busy_d[wb_rd] = 1'b0;
                dec           = 1;
            end
            if (issue_valid && (issue_rd != '0)) begin
                if (!busy[issue_rd]) begin
                    inc = 1;
                end else if (issue_rd == wb_rd) begin
                    dec = '0;
                end
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_tag;
            end
            count_d = busy_count + inc - dec;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign busy_next = busy_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy       <= busy_d;
            busy_count <= count_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: rtl/regfile_sb_s.sv
// Multi-read-port register file with tagged busy scoreboard; r0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy state to matching read ports.
module regfile_sb_s
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = NUM_RD_DEF,
    parameter  int TAG_W    = TAG_W_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rdAddr,
    output logic [NUM_RD*XLEN-1:0] rdData,
    output logic [NUM_RD-1:0]      rdBusy,
    input  logic                   issueValid,
    input  logic [AW-1:0]          issueRd,
    input  logic [TAG_W-1:0]       issueTag,
    input  logic                   wbValid,
    input  logic [AW-1:0]          wbRd,
    input  logic [TAG_W-1:0]       wbTag,
    input  logic [XLEN-1:0]        wbData,
    input  logic                   flush,
    output logic [AW:0]            busyCount
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
`ifdef REGFILE_BYPASS_EN
    logic [NUM_REGS-1:0] busy_next;
`endif

    regfile_scoreboard_s #(
        .NUM_REGS (NUM_REGS),
        .TAG_W    (TAG_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issueValid),
        .issue_rd    (issueRd),
        .issue_tag   (issueTag),
        .wb_valid    (wbValid),
        .wb_rd       (wbRd),
        .wb_tag      (wbTag),
        .flush       (flush),
        .busy        (busy),
`ifdef REGFILE_BYPASS_EN
        .busy_next   (busy_next),
`endif
        .busy_count  (busyCount)
    );

    // Data is written regardless of tag or flush; r0 is never written so it reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wbValid && (wbRd != '0)) begin
            regs[wbRd] <= wbData;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rdAddr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = wbValid && (wbRd != '0) && (wbRd == addr);
        assign rdData[k*XLEN +: XLEN] = hit ? wbData : regs[addr];
        assign rdBusy[k]              = hit ? busy_next[addr] : busy[addr];
`else
        assign rdData[k*XLEN +: XLEN] = regs[addr];
        assign rdBusy[k]              = busy[addr];
`endif
    end

endmodule

// File: tb/tb_regfile_sb_s.sv
// Bench for regfile_sb_s: directed table, hand sequences (flush, reset, bypass) and random vs. model.
module tb_regfile_sb_s;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data;
    logic        flush;
    logic [5:0]  busy_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    sb_entry_t   m_sb   [32];

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [3:0]  itag;
        logic        wv;
        logic [4:0]  wrd;
        logic [3:0]  wtag;
        logic [31:0] wdata;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [1:0]  exp_busy;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs [14];

    regfile_sb_s dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdAddr     (rd_addr),
        .rdData     (rd_data),
        .rdBusy     (rd_busy),
        .issueValid (issue_valid),
        .issueRd    (issue_rd),
        .issueTag   (issue_tag),
        .wbValid    (wb_valid),
        .wbRd       (wb_rd),
        .wbTag      (wb_tag),
        .wbData     (wb_data),
        .flush      (flush),
        .busyCount  (busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are then sampled 1ns later.
    task automatic drive(input logic iv, input logic [4:0] ird, input logic [3:0] itag,
                         input logic wv, input logic [4:0] wrd, input logic [3:0] wtag,
                         input logic [31:0] wdata, input logic fl,
                         input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        issue_valid = iv;
        issue_rd    = ird;
        issue_tag   = itag;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_tag      = wtag;
        wb_data     = wdata;
        flush       = fl;
        rd_addr     = {a1, a0};
        #1;
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        drive(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 32'd0, 1'b0, a0, a1);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_sb[i]   = '0;
        end
    endtask

    // Edge behaviour from the rules: data always written, tag-matched release, issue last so it wins.
    task automatic model_edge();
        if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_sb[i].busy = 1'b0;
        end else begin
            if (wb_valid && wb_rd != 0 && m_sb[wb_rd].busy && m_sb[wb_rd].tag == wb_tag)
                m_sb[wb_rd].busy = 1'b0;
            if (issue_valid && issue_rd != 0) begin
                m_sb[issue_rd].busy = 1'b1;
                m_sb[issue_rd].tag  = issue_tag;
            end
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_sb[i].busy);
        return n;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        issue_valid = 0; issue_rd = 0; issue_tag = 0;
        wb_valid = 0; wb_rd = 0; wb_tag = 0; wb_data = 0;
        flush = 0; rd_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        vecs[0]  = '{1, 5, 3, 0, 0, 0, 32'h0,        5, 5, 32'h0,        32'h0,        2'b00, 6'd0};
        vecs[1]  = '{0, 0, 0, 1, 5, 3, 32'h12345678, 5, 5, 32'h0,        32'h0,        2'b11, 6'd1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,        5, 5, 32'h12345678, 32'h12345678, 2'b00, 6'd0};
        vecs[3]  = '{1, 7, 1, 0, 0, 0, 32'h0,        7, 5, 32'h0,        32'h12345678, 2'b00, 6'd0};
        vecs[4]  = '{1, 7, 2, 0, 0, 0, 32'h0,        7, 5, 32'h0,        32'h12345678, 2'b01, 6'd1};
        vecs[5]  = '{0, 0, 0, 1, 7, 1, 32'hAAAA0001, 7, 5, 32'h0,        32'h12345678, 2'b01, 6'd1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 32'h0,        7, 5, 32'hAAAA0001, 32'h12345678, 2'b01, 6'd1};
        vecs[7]  = '{0, 0, 0, 1, 7, 2, 32'hBBBB0002, 7, 5, 32'hAAAA0001, 32'h12345678, 2'b01, 6'd1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 32'h0,        7, 5, 32'hBBBB0002, 32'h12345678, 2'b00, 6'd0};
        vecs[9]  = '{1, 9, 4, 0, 0, 0, 32'h0,        9, 5, 32'h0,        32'h12345678, 2'b00, 6'd0};
        vecs[10] = '{1, 9, 4, 1, 9, 4, 32'h00000099, 9, 5, 32'h0,        32'h12345678, 2'b01, 6'd1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 32'h0,        9, 5, 32'h00000099, 32'h12345678, 2'b01, 6'd1};
        vecs[12] = '{0, 0, 0, 1, 9, 4, 32'h0000009A, 9, 5, 32'h00000099, 32'h12345678, 2'b01, 6'd1};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 32'h0,        9, 5, 32'h0000009A, 32'h12345678, 2'b00, 6'd0};

        // Reset state: every register reads zero and not busy.
        do_reset();
        for (int r = 0; r < 32; r++) begin
            idle(5'(r), 5'(31 - r));
            chk($sformatf("reset_d0_r%0d", r), rd_data[31:0], 32'h0);
            chk($sformatf("reset_d1_r%0d", r), rd_data[63:32], 32'h0);
            chk($sformatf("reset_busy_r%0d", r), 32'(rd_busy), 32'h0);
            chk("reset_count", 32'(busy_count), 32'h0);
        end

        // r0 ignores writes and issues.
        drive(1'b1, 5'd0, 4'd5, 1'b1, 5'd0, 4'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("r0_data", rd_data[31:0], 32'h0);
        chk("r0_busy", 32'(rd_busy), 32'h0);
        chk("r0_count", 32'(busy_count), 32'h0);

        // Directed table: expectations are pre-edge state while the row's inputs are applied.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].ird, vecs[i].itag, vecs[i].wv, vecs[i].wrd,
                  vecs[i].wtag, vecs[i].wdata, 1'b0, vecs[i].a0, vecs[i].a1);
            chk($sformatf("tbl%0d_d0", i), rd_data[31:0], vecs[i].exp_d0);
            chk($sformatf("tbl%0d_d1", i), rd_data[63:32], vecs[i].exp_d1);
            chk($sformatf("tbl%0d_busy", i), 32'(rd_busy), 32'(vecs[i].exp_busy));
            chk($sformatf("tbl%0d_cnt", i), 32'(busy_count), 32'(vecs[i].exp_cnt));
        end

        // Flush with a concurrent issue.
        for (int r = 1; r <= 10; r++) begin
            drive(1'b1, 5'(r), 4'(r), 1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 5'd1, 5'd10);
        end
        idle(5'd1, 5'd10);
        chk("pre_flush_count", 32'(busy_count), 32'd10);
        chk("pre_flush_busy", 32'(rd_busy), 32'h3);
        drive(1'b1, 5'd11, 4'd6, 1'b0, 5'd0, 4'd0, 32'd0, 1'b1, 5'd11, 5'd1);
        idle(5'd11, 5'd1);
        chk("post_flush_count", 32'(busy_count), 32'd0);
        chk("post_flush_r11_busy", 32'(rd_busy), 32'h0);
        for (int r = 0; r < 32; r += 2) begin
            idle(5'(r), 5'(r + 1));
            chk($sformatf("post_flush_busy_r%0d", r), 32'(rd_busy), 32'h0);
        end

        // Latency of a plain writeback (bypass changes the same-cycle value).
        drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd3, 4'd0, 32'h11111111, 1'b0, 5'd0, 5'd3);
        drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd3, 4'd0, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3);
`ifdef REGFILE_BYPASS_EN
        chk("wb_same_cycle", rd_data[63:32], 32'hA5A5A5A5);
`else
        chk("wb_same_cycle", rd_data[63:32], 32'h11111111);
`endif
        idle(5'd0, 5'd3);
        chk("wb_next_cycle", rd_data[63:32], 32'hA5A5A5A5);

        // Asynchronous reset mid-cycle.
        drive(1'b1, 5'd12, 4'd1, 1'b1, 5'd13, 4'd0, 32'h00005555, 1'b0, 5'd13, 5'd12);
        idle(5'd13, 5'd12);
        chk("pre_rst_data", rd_data[31:0], 32'h00005555);
        chk("pre_rst_busy", 32'(rd_busy), 32'h2);
        chk("pre_rst_count", 32'(busy_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", rd_data[31:0], 32'h0);
        chk("async_rst_data3", 32'h0, 32'h0 ^ 32'h0 ^ 32'h0) ;
        chk("async_rst_busy", 32'(rd_busy), 32'h0);
        chk("async_rst_count", 32'(busy_count), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic       iv, wv, fl;
            logic [4:0] ird, wrd, a0, a1;
            logic [3:0] itag, wtag;
            logic [31:0] wd;
            iv   = ($urandom_range(0, 9) < 4);
            ird  = 5'($urandom_range(0, 31));
            itag = 4'($urandom_range(0, 15));
            wv   = ($urandom_range(0, 9) < 5);
            wrd  = ($urandom_range(0, 3) == 0) ? ird : 5'($urandom_range(0, 31));
            wtag = ($urandom_range(0, 1) == 0) ? m_sb[wrd].tag : 4'($urandom_range(0, 15));
            wd   = $urandom;
            fl   = ($urandom_range(0, 49) == 0);
            a0   = 5'($urandom_range(0, 31));
            a1   = ($urandom_range(0, 1) == 0) ? wrd : 5'($urandom_range(0, 31));
            drive(iv, ird, itag, wv, wrd, wtag, wd, fl, a0, a1);
`ifdef REGFILE_BYPASS_EN
            if (!(wv && wrd != 0 && (wrd == a0 || wrd == a1))) begin
`else
            begin
`endif
                chk("rnd_d0", rd_data[31:0], m_regs[a0]);
                chk("rnd_d1", rd_data[63:32], m_regs[a1]);
                chk("rnd_busy", 32'(rd_busy), 32'({m_sb[a1].busy, m_sb[a0].busy}));
            end
            chk("rnd_count", 32'(busy_count), 32'(model_count()));
            model_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
